alu_control_32: RTL and testbench

- MIPS-style ALU control decoder for the 32-bit datapath.
- Maps the main-control ALUop field and the R-type function field to a 4-bit ALU operation code.
- Flags illegal ALUop and illegal function codes.
- Registered, with a start/finish handshake, so the sequencing controller can launch a decode and see a one-cycle completion pulse.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_func_decode.sv | 51 +++++
 rtl/alu_control_32.sv | 76 +++++++
 tb/tb_alu_control_32.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUop, function-code and ALU control-code constants
//               for the 32-bit datapath ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALUop field as driven by the main control unit
    typedef enum logic [1:0] {
        ALUOP_MEM     = 2'b00,
        ALUOP_BRANCH  = 2'b01,
        ALUOP_RTYPE   = 2'b10,
        ALUOP_ILLEGAL = 2'b11
    } alu_op_e;

    // R-type function field codes that the ALU supports
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    // ALU operation codes presented to the datapath ALU
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_func_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_func_decode
// Description : Purely combinational mapping of ALUop / function field to
//               the ALU operation code plus illegal-code flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_func_decode
    import alu_pkg::*;
#(
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4
) (
    input  logic [FUNC_W-1:0]  func,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               err_func,
    output logic               err_op
);

    // Decode; anything not explicitly legal (including X/Z) lands in a default
    always_comb begin
        ctrl     = ALU_INVALID;
        err_func = 1'b0;
        err_op   = 1'b0;
        case (alu_op)
            ALUOP_MEM:    ctrl = ALU_ADD;
            ALUOP_BRANCH: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (func)
                    FUNC_ADD: ctrl = ALU_ADD;
                    FUNC_SUB: ctrl = ALU_SUB;
                    FUNC_AND: ctrl = ALU_AND;
                    FUNC_OR:  ctrl = ALU_OR;
                    FUNC_SLT: ctrl = ALU_SLT;
                    default: begin
                        ctrl     = ALU_INVALID;
                        err_func = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl   = ALU_INVALID;
                err_op = 1'b1;
            end
        endcase
    end

endmodule : alu_func_decode
`default_nettype wire

// File: rtl/alu_control_32.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_32
// Description : Registered ALU control decoder with start/finish handshake.
//               A decode is captured on each rising edge with start high and
//               finish pulses in the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_32
    import alu_pkg::*;
#(
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FUNC_W-1:0]  func,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [CTRL_W-1:0]  alu_control,
    output logic               err_illegal_func_code,
    output logic               err_illegal_alu_op,
    output logic               finish
);

    logic [CTRL_W-1:0] w_ctrl;
    logic              w_err_func;
    logic              w_err_op;

    logic [CTRL_W-1:0] r_alu_control;
    logic              r_err_func;
    logic              r_err_op;
    logic              r_finish;

    alu_func_decode #(
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .func     (func),
        .alu_op   (alu_op),
        .ctrl     (w_ctrl),
        .err_func (w_err_func),
        .err_op   (w_err_op)
    );

    // Capture the decode only on start edges; otherwise hold the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_control <= '0;
            r_err_func    <= 1'b0;
            r_err_op      <= 1'b0;
        end else if (start) begin
            r_alu_control <= w_ctrl;
            r_err_func    <= w_err_func;
            r_err_op      <= w_err_op;
        end
    end

    // finish mirrors the sampled start, so back-to-back starts keep it high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_finish <= 1'b0;
        end else begin
            r_finish <= start;
        end
    end

    assign alu_control           = r_alu_control;
    assign err_illegal_func_code = r_err_func;
    assign err_illegal_alu_op    = r_err_op;
    assign finish                = r_finish;

endmodule : alu_control_32
`default_nettype wire

// File: tb/tb_alu_control_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_32
// Description : Scoreboard bench for alu_control_32. The driver pushes the
//               expected decode for every start; the monitor pops on finish
//               and otherwise checks that the outputs hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_32;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ef;
        logic       eo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] func;
    logic [1:0] alu_op;
    logic [3:0] alu_control;
    logic       err_illegal_func_code;
    logic       err_illegal_alu_op;
    logic       finish;

    exp_t sb[$];
    exp_t hold;
    int   n_cmp;
    int   n_fail;
    int   rtype_map[int];

    alu_control_32 dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .func                  (func),
        .alu_op                (alu_op),
        .alu_control           (alu_control),
        .err_illegal_func_code (err_illegal_func_code),
        .err_illegal_alu_op    (err_illegal_alu_op),
        .finish                (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ALUop picks a fixed op, R-type looks up a table of supported codes
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
        exp_t e;
        e = '{ctrl: 4'd0, ef: 1'b0, eo: 1'b0};
        if (op == 2'd0)      e.ctrl = 4'd2;
        else if (op == 2'd1) e.ctrl = 4'd6;
        else if (op == 2'd3) begin e.ctrl = 4'd15; e.eo = 1'b1; end
        else if (rtype_map.exists(int'(f))) e.ctrl = 4'(rtype_map[int'(f)]);
        else begin e.ctrl = 4'd15; e.ef = 1'b1; end
        return e;
    endfunction

    function automatic void check(input string name, input exp_t got, input exp_t want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%b ef=%b eo=%b, want ctrl=%b ef=%b eo=%b",
                     name, got.ctrl, got.ef, got.eo, want.ctrl, want.ef, want.eo);
        end
    endfunction

    function automatic void check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endfunction

    task automatic issue(input logic s, input logic [1:0] op, input logic [5:0] f);
        @(negedge clk);
        start  = s;
        alu_op = op;
        func   = f;
        if (s) sb.push_back(model(op, f));
    endtask

    // Monitor: pop on finish, otherwise outputs must hold the last decode
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (finish) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL finish_unexpected: got finish=1, want no pending decode");
                end else begin
                    hold = sb.pop_front();
                    n_cmp--;
                    check("decode", {alu_control, err_illegal_func_code, err_illegal_alu_op}, hold);
                end
            end else begin
                check("hold", {alu_control, err_illegal_func_code, err_illegal_alu_op}, hold);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want run complete");
        $fatal(1, "timeout");
    end

    logic [5:0] legal_f   [5];
    logic [5:0] illegal_f [5];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        hold   = '0;
        rtype_map[32] = 2;  // add
        rtype_map[34] = 6;  // sub
        rtype_map[36] = 0;  // and
        rtype_map[37] = 1;  // or
        rtype_map[42] = 7;  // slt
        legal_f   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        illegal_f = '{6'b111010, 6'b111111, 6'b110110, 6'b110101, 6'b101011};
        rst_n  = 1'b0;
        start  = 1'b0;
        func   = '0;
        alu_op = '0;
        #3;
        check("reset_out", {alu_control, err_illegal_func_code, err_illegal_alu_op}, '0);
        check_bit("reset_finish", finish, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) issue(1'b0, 2'b10, 6'b111111);

        // Mem and branch ignore func
        foreach (legal_f[i]) issue(1'b1, 2'b00, legal_f[i]);
        foreach (legal_f[i]) issue(1'b1, 2'b01, legal_f[i]);
        // R-type legal then illegal codes
        foreach (legal_f[i]) issue(1'b1, 2'b10, legal_f[i]);
        foreach (illegal_f[i]) issue(1'b1, 2'b10, illegal_f[i]);
        // Illegal ALUop, then a legal decode clears it
        issue(1'b1, 2'b11, 6'b111010);
        issue(1'b1, 2'b11, 6'b100000);
        issue(1'b1, 2'b00, 6'b000000);
        // Single pulse followed by input churn with start low
        issue(1'b0, 2'b00, 6'b0);
        issue(1'b1, 2'b10, 6'b100101);
        issue(1'b0, 2'b11, 6'b111111);
        issue(1'b0, 2'b10, 6'b000001);
        issue(1'b0, 2'b01, 6'b101010);
        // Start held high for three cycles
        issue(1'b1, 2'b10, 6'b101010);
        issue(1'b1, 2'b11, 6'b000000);
        issue(1'b1, 2'b10, 6'b100100);
        issue(1'b0, 2'b00, 6'b0);

        // Asynchronous reset mid-cycle clears outputs and the pending finish
        issue(1'b1, 2'b11, 6'b010101);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        hold  = '0;
        #1;
        check("midreset_out", {alu_control, err_illegal_func_code, err_illegal_alu_op}, '0);
        check_bit("midreset_finish", finish, 1'b0);
        issue(1'b0, 2'b00, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) issue(1'b0, 2'b10, 6'b110000);

        // Randomized traffic biased toward legal R-type codes
        for (int n = 0; n < 300; n++) begin
            logic       s;
            logic [1:0] op;
            logic [5:0] f;
            s  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) f = legal_f[$urandom_range(0, 4)];
            else                           f = 6'($urandom);
            issue(s, op, f);
        end
        issue(1'b0, 2'b00, 6'b0);
        repeat (3) @(negedge clk);

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d decodes without finish, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu_control_32
`default_nettype wire
